// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code assembler: pops receiver FIFO bytes, folds E0/F0
// prefixes into key events. Optional modifier tracking: PS2_KEY_STATUS_EN.
module ps2_key_ctrl #(
  parameter logic [31:0] TIMEOUT = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_overflow,
  output logic       ps2_rdn,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       err,
  output logic [3:0] mods
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    HOLD
  } state_t;

  state_t      state;
  logic [7:0]  byte_q;
  logic        ext_f;
  logic        brk_f;
  logic [31:0] cnt;
  logic        ovf_q;

  logic ovf_edge;
  logic tmo;
  logic is_e0;
  logic is_f0;
  logic is_aa;
  logic is_bad;

  assign ovf_edge = ps2_overflow & ~ovf_q;
  assign tmo      = (state == IDLE) && !ps2_ready &&
                    (ext_f | brk_f) &&
                    (cnt == TIMEOUT - 32'd1);
  assign is_e0    = (byte_q == 8'hE0);
  assign is_f0    = (byte_q == 8'hF0);
  assign is_aa    = (byte_q == 8'hAA);
  assign is_bad   = (byte_q == 8'h00) || (byte_q == 8'hFF);

  // Sequencer: pop, decode prefixes, hold the event until acknowledged.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      ps2_rdn   <= 1'b1;
      byte_q    <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q   <= ps2_overflow;
      err     <= 1'b0;
      ps2_rdn <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ps2_ready) begin
            state   <= FETCH;
            ps2_rdn <= 1'b0;
          end
        end
        FETCH: begin
          byte_q <= ps2_byte;
          state  <= DECODE;
        end
        DECODE: begin
          state <= IDLE;
          unique case (1'b1)
            is_e0: ext_f <= 1'b1;
            is_f0: brk_f <= 1'b1;
            is_aa: begin
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end
            is_bad: begin
              err   <= 1'b1;
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end
            default: begin
              key_code  <= byte_q;
              key_ext   <= ext_f;
              key_break <= brk_f;
              key_valid <= 1'b1;
              state     <= HOLD;
            end
          endcase
        end
        HOLD: begin
          if (key_ack) begin
            key_valid <= 1'b0;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
      // Stale prefix or lost bytes: drop prefixes, flag once.
      if (tmo || ovf_edge) begin
        err   <= 1'b1;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  // Prefix age counter: counts idle cycles while a prefix is pending.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= 32'd0;
    end else if (!(ext_f | brk_f)) begin
      cnt <= 32'd0;
    end else if (state == IDLE) begin
      if (ps2_ready || tmo) begin
        cnt <= 32'd0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

`ifdef PS2_KEY_STATUS_EN
  logic shift_q;
  logic ctrl_q;
  logic alt_q;
  logic caps_q;
  logic caps_held;
  logic dec_evt;

  assign dec_evt = (state == DECODE) &&
                   !(is_e0 | is_f0 | is_aa | is_bad);

  // Modifier state follows each event as it is loaded for the consumer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shift_q   <= 1'b0;
      ctrl_q    <= 1'b0;
      alt_q     <= 1'b0;
      caps_q    <= 1'b0;
      caps_held <= 1'b0;
    end else if (dec_evt) begin
      if ((byte_q == 8'h12 || byte_q == 8'h59) && !ext_f) begin
        shift_q <= ~brk_f;
      end
      if (byte_q == 8'h14) begin
        ctrl_q <= ~brk_f;
      end
      if (byte_q == 8'h11) begin
        alt_q <= ~brk_f;
      end
      if (byte_q == 8'h58) begin
        if (brk_f) begin
          caps_held <= 1'b0;
        end else begin
          caps_held <= 1'b1;
          if (!caps_held) begin
            caps_q <= ~caps_q;
          end
        end
      end
    end
  end

  assign mods = {caps_q, alt_q, ctrl_q, shift_q};
`else
  assign mods = 4'b0000;
`endif

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 32'd5_000_000, idle cycles allowed between a prefix byte and its following byte.
REQ-002 clk  in  1  system clock, 50 MHz; all state changes on rising edge.
REQ-003 clr  in  1  asynchronous active-high reset.
REQ-004 ps2_ready  in  1  receiver FIFO non-empty.
REQ-005 ps2_byte  in  8  receiver FIFO head byte; valid while ps2_ready=1.
REQ-006 ps2_overflow  in  1  receiver FIFO overflow flag.
REQ-007 ps2_rdn  out  1  FIFO read strobe, active low; one clock wide per pop.
REQ-008 key_code  out  8  scan code of the current event.
REQ-009 key_ext  out  1  event was E0-prefixed.
REQ-010 key_break  out  1  event is a release (F0-prefixed).
REQ-011 key_valid  out  1  event held on key_* outputs.
REQ-012 key_ack  in  1  consumer accepts the event.
REQ-013 err  out  1  one-cycle error pulse.
REQ-014 mods  out  4  {caps_lock, alt, ctrl, shift} modifier status.

Function
REQ-015 The states SHALL be IDLE, FETCH, DECODE and HOLD.
REQ-016 IDLE SHALL go to FETCH when ps2_ready=1; otherwise it SHALL stay in IDLE.
REQ-017 In FETCH, ps2_rdn SHALL be 0 for exactly one cycle, and ps2_byte SHALL be latched on the edge that ends FETCH; next state is DECODE.
REQ-018 ps2_rdn SHALL be a registered output and SHALL be 1 in every state except FETCH.
REQ-019 DECODE 0xE0: set the ext flag, go to IDLE, no event.
REQ-020 DECODE 0xF0: set the brk flag, go to IDLE, no event.
REQ-021 DECODE 0xAA: discard the byte, clear both flags, go to IDLE, no event and no err.
REQ-022 DECODE 0x00 or 0xFF: pulse err for one cycle, clear both flags, go to IDLE.
REQ-023 DECODE other bytes: load key_code=byte, key_ext=ext, key_break=brk, set key_valid=1, go to HOLD; total latency from ps2_ready rising in IDLE to key_valid=1 is 3 cycles.
REQ-024 HOLD SHALL keep all key_* outputs stable until a cycle with key_ack=1; on that edge key_valid SHALL clear, both flags SHALL clear, and next state is IDLE.
REQ-025 No FIFO pop SHALL occur while in HOLD; back-pressure is absorbed by the receiver FIFO.
REQ-026 key_ack=1 outside HOLD SHALL be ignored.
REQ-027 Prefix timeout: a 32-bit counter SHALL run in IDLE while ext or brk is set, and SHALL reset whenever FETCH is entered or both flags are clear.
REQ-028 Prefix timeout: when the counter reaches TIMEOUT-1, both flags SHALL clear and err SHALL pulse once.
REQ-029 A rising edge of ps2_overflow (registered previous value 0, current 1) SHALL pulse err and clear both flags; a held event in HOLD is unaffected.
REQ-030 Simultaneous overflow-edge and timeout in one cycle SHALL produce a single err pulse.
REQ-031 Simultaneous overflow-edge and DECODE of a prefix: the overflow clear wins (flags end 0).

Reset
REQ-032 On clr=1 the block SHALL asynchronously enter IDLE, independent of clk.
REQ-033 Reset values: ps2_rdn=1, key_valid=0, key_code=0, key_ext=0, key_break=0, err=0, mods=0, flags=0, counter=0, overflow history=0.
REQ-034 Reset asserted during FETCH SHALL force ps2_rdn=1 immediately; at most that one byte is lost.

Configuration
REQ-035 Macro PS2_KEY_STATUS_EN: when defined, mods SHALL track key events as they enter HOLD.
REQ-036 With PS2_KEY_STATUS_EN: shift (codes 0x12/0x59, ext=0) is set on make and cleared on break.
REQ-037 With PS2_KEY_STATUS_EN: ctrl (0x14, either ext) and alt (0x11, either ext) are set on make and cleared on break.
REQ-038 With PS2_KEY_STATUS_EN: caps_lock toggles on make of 0x58 only if 0x58 was not already held, so typematic repeats do not toggle.
REQ-039 Without PS2_KEY_STATUS_EN: mods SHALL be constant 4'b0000 and no tracking registers SHALL exist.

Verification
REQ-040 FIFO holds 0x1C, key_ack tied 1 -> one ps2_rdn low cycle, key_valid=1 with key_code=0x1C, ext=0, break=0, 3 cycles after ps2_ready.
REQ-041 Bytes E0,F0,75 -> exactly three pops, one event: key_code=0x75, ext=1, break=1; no event for the prefixes.
REQ-042 Bytes 0x1C, 0x32 with key_ack=0 for 20 cycles -> key_code stays 0x1C, second pop occurs only after key_ack=1.
REQ-043 TIMEOUT=16: F0 then no data for 16 cycles -> err pulse; then byte 0x1C -> break=0.
REQ-044 STATUS_EN defined: 12, 58, F0 58, 58, F0 12 -> mods sequence shift=1, caps=1, caps stays 1, caps=0, shift=0.
REQ-045 clr pulse mid-FETCH -> ps2_rdn=1 and key_valid=0 within the same cycle, state IDLE.
